rotate_addr_gen: RTL

//  Parametrised successor of the fixed 90-degree rotator in the camera-to-frame-buffer path.

---
 rtl/rotate_addr_gen_pkg.sv | 21 ++
 rtl/rotate_addr_gen_if.sv | 50 +++++
 rtl/rotate_addr_gen_rot_addr_calc.sv | 82 ++++++++
 rtl/rotate_addr_gen.sv | 113 +++++++++++
 4 files changed

// File: rtl/rotate_addr_gen_pkg.sv
// rotate_pkg: shared types and helpers for the rotating frame-buffer address
// generator.
//   rot_mode_t   rotation selector (0, 90, 180, 270 degrees)
//   HCOUNT_W     width of the raster column counter
//   VCOUNT_W     width of the raster row counter
//   rot_last_px  true when (h,v) is the bottom-right pixel of a w x hgt image
package rotate_pkg;

  typedef enum logic [1:0] {ROT_0, ROT_90, ROT_180, ROT_270} rot_mode_t;

  localparam int HCOUNT_W = 11;
  localparam int VCOUNT_W = 10;

  function automatic logic rot_last_px(input logic [HCOUNT_W-1:0] h,
                                       input logic [VCOUNT_W-1:0] v,
                                       input int w,
                                       input int hgt);
    return (h == HCOUNT_W'(w - 1)) && (v == VCOUNT_W'(hgt - 1));
  endfunction

endpackage

// File: rtl/rotate_addr_gen_if.sv
// rotate_addr_gen_if: pixel stream bundle between the pixel reconstructor
// (master) and the rotating address generator (slave).
//   Inputs to the generator : mode_in, hcount_in, vcount_in, data_valid_in,
//                             pixel_in, and mirror_in when ROTATE_MIRROR_EN
//                             is defined.
//   Outputs of the generator: pixel_out, pixel_addr_out, data_valid_out,
//                             hcount_out, vcount_out, frame_done_out,
//                             mode_active_out.
interface rotate_addr_gen_if #(
  parameter int PIX_W  = 16,
  parameter int ADDR_W = 17
);
  import rotate_pkg::*;

  logic [1:0]          mode_in;
  logic [HCOUNT_W-1:0] hcount_in;
  logic [VCOUNT_W-1:0] vcount_in;
  logic                data_valid_in;
  logic [PIX_W-1:0]    pixel_in;
`ifdef ROTATE_MIRROR_EN
  logic                mirror_in;
`endif

  logic [PIX_W-1:0]    pixel_out;
  logic [ADDR_W-1:0]   pixel_addr_out;
  logic                data_valid_out;
  logic [HCOUNT_W-1:0] hcount_out;
  logic [VCOUNT_W-1:0] vcount_out;
  logic                frame_done_out;
  logic [1:0]          mode_active_out;

  modport master (
    output mode_in, hcount_in, vcount_in, data_valid_in, pixel_in,
`ifdef ROTATE_MIRROR_EN
    output mirror_in,
`endif
    input  pixel_out, pixel_addr_out, data_valid_out, hcount_out,
           vcount_out, frame_done_out, mode_active_out
  );

  modport slave (
    input  mode_in, hcount_in, vcount_in, data_valid_in, pixel_in,
`ifdef ROTATE_MIRROR_EN
    input  mirror_in,
`endif
    output pixel_out, pixel_addr_out, data_valid_out, hcount_out,
           vcount_out, frame_done_out, mode_active_out
  );

endinterface

// File: rtl/rotate_addr_gen_rot_addr_calc.sv
// rot_addr_calc: two-stage registered multiply-add that maps a raster
// coordinate to a frame-buffer address for the selected rotation.
//   clk_in, rst_in : clock and synchronous active-high reset
//   mode           : rotation applied to this coordinate
//   h, v           : (possibly mirrored) column and row
//   addr           : address, valid two clocks after h/v/mode
// Stage 1 registers the product term and the offset term, stage 2 adds them.
// Arithmetic runs one bit wider than the address and is truncated at the end.
module rot_addr_calc
  import rotate_pkg::*;
#(
  parameter int SRC_W  = 320,
  parameter int SRC_H  = 240,
  parameter int ADDR_W = 17
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  rot_mode_t           mode,
  input  logic [HCOUNT_W-1:0] h,
  input  logic [VCOUNT_W-1:0] v,
  output logic [ADDR_W-1:0]   addr
);

  localparam int PW = ADDR_W + 1;

  localparam logic [PW-1:0] W_C   = PW'(SRC_W);
  localparam logic [PW-1:0] H_C   = PW'(SRC_H);
  localparam logic [PW-1:0] W_M1  = PW'(SRC_W - 1);
  localparam logic [PW-1:0] H_M1  = PW'(SRC_H - 1);

  logic [PW-1:0]     h_x, v_x;
  logic [PW-1:0]     prod_d, prod_q;
  logic [PW-1:0]     off_d, off_q;
  logic [ADDR_W-1:0] addr_d, addr_q;

  assign h_x = PW'(h);
  assign v_x = PW'(v);

  always_comb begin
    prod_d = '0;
    off_d  = '0;
    case (mode)
      ROT_0: begin
        prod_d = v_x * W_C;
        off_d  = h_x;
      end
      ROT_90: begin
        prod_d = (W_M1 - h_x) * H_C;
        off_d  = v_x;
      end
      ROT_180: begin
        prod_d = (H_M1 - v_x) * W_C;
        off_d  = W_M1 - h_x;
      end
      ROT_270: begin
        prod_d = h_x * H_C;
        off_d  = H_M1 - v_x;
      end
      default: begin
        prod_d = '0;
        off_d  = '0;
      end
    endcase
  end

  assign addr_d = ADDR_W'(prod_q + off_q);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      prod_q <= '0;
      off_q  <= '0;
      addr_q <= '0;
    end else begin
      prod_q <= prod_d;
      off_q  <= off_d;
      addr_q <= addr_d;
    end
  end

  assign addr = addr_q;

endmodule

// File: rtl/rotate_addr_gen.sv
// rotate_addr_gen: maps camera raster coordinates to a frame-buffer write
// address for one of four rotations; pixel, valid, coordinates and
// frame_done travel a fixed 2-stage pipeline aligned with the address.
//   clk_in  : pixel clock
//   rst_in  : synchronous active-high reset, flushes the pipeline
//   bus     : rotate_addr_gen_if.slave stream (inputs mode/h/v/valid/pixel,
//             outputs pixel/addr/valid/h/v/frame_done/mode_active)
// Optional feature: define ROTATE_MIRROR_EN to add bus.mirror_in, a
// horizontal flip latched together with the mode at frame start.
module rotate_addr_gen
  import rotate_pkg::*;
#(
  parameter int         SRC_W        = 320,
  parameter int         SRC_H        = 240,
  parameter int         PIX_W        = 16,
  parameter int         ADDR_W       = $clog2(SRC_W * SRC_H),
  parameter logic [1:0] MODE_DEFAULT = 2'd1
) (
  input logic             clk_in,
  input logic             rst_in,
  rotate_addr_gen_if.slave bus
);

  logic                frame_start;
  logic                in_range;
  logic [HCOUNT_W-1:0] h_map;
  rot_mode_t           mode_d, mode_q;

  logic                valid1_q, valid2_q;
  logic                last1_q, last2_q;
  logic [PIX_W-1:0]    pix1_q, pix2_q;
  logic [HCOUNT_W-1:0] h1_q, h2_q;
  logic [VCOUNT_W-1:0] v1_q, v2_q;
  logic [ADDR_W-1:0]   calc_addr;

  // The (0,0) cycle itself already uses the freshly requested mode, so the
  // mapping is fed from mode_d rather than the register.
  assign frame_start = bus.data_valid_in && (bus.hcount_in == '0) && (bus.vcount_in == '0);
  assign mode_d      = frame_start ? rot_mode_t'(bus.mode_in) : mode_q;
  assign in_range    = bus.data_valid_in
                    && (bus.hcount_in < HCOUNT_W'(SRC_W))
                    && (bus.vcount_in < VCOUNT_W'(SRC_H));

`ifdef ROTATE_MIRROR_EN
  logic mirror_d, mirror_q;

  assign mirror_d = frame_start ? bus.mirror_in : mirror_q;

  always_comb begin
    h_map = bus.hcount_in;
    if (mirror_d) h_map = HCOUNT_W'(SRC_W - 1) - bus.hcount_in;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) mirror_q <= 1'b0;
    else        mirror_q <= mirror_d;
  end
`else
  assign h_map = bus.hcount_in;
`endif

  rot_addr_calc #(
    .SRC_W  (SRC_W),
    .SRC_H  (SRC_H),
    .ADDR_W (ADDR_W)
  ) u_calc (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .mode   (mode_d),
    .h      (h_map),
    .v      (bus.vcount_in),
    .addr   (calc_addr)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      mode_q   <= rot_mode_t'(MODE_DEFAULT);
      valid1_q <= 1'b0;
      valid2_q <= 1'b0;
      last1_q  <= 1'b0;
      last2_q  <= 1'b0;
      pix1_q   <= '0;
      pix2_q   <= '0;
      h1_q     <= '0;
      h2_q     <= '0;
      v1_q     <= '0;
      v2_q     <= '0;
    end else begin
      mode_q   <= mode_d;
      valid1_q <= in_range;
      valid2_q <= valid1_q;
      last1_q  <= in_range && rot_last_px(bus.hcount_in, bus.vcount_in, SRC_W, SRC_H);
      last2_q  <= last1_q;
      pix1_q   <= bus.pixel_in;
      pix2_q   <= pix1_q;
      h1_q     <= bus.hcount_in;
      h2_q     <= h1_q;
      v1_q     <= bus.vcount_in;
      v2_q     <= v1_q;
    end
  end

  // Out-of-range coordinates still run through the multiplier; their address
  // is forced to zero here instead of gating the arithmetic.
  assign bus.pixel_addr_out  = valid2_q ? calc_addr : '0;
  assign bus.data_valid_out  = valid2_q;
  assign bus.frame_done_out  = last2_q;
  assign bus.pixel_out       = pix2_q;
  assign bus.hcount_out      = h2_q;
  assign bus.vcount_out      = v2_q;
  assign bus.mode_active_out = mode_q;

endmodule
